// File: rtl/prox_pkg.sv
// Shared types and default timing for the proximity ping scheduler.
// The default timing values assume a 100 MHz clock.
package prox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_GAP
  } state_t;

  localparam int DEF_TRIG_CYCLES    = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 2500000;
  localparam int DEF_GAP_CYCLES     = 6000000;
  localparam int DEF_THRESH_CYCLES  = 116000;
  localparam int DEF_HYST_CYCLES    = 12000;

  // Width of a sensor index, never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings one raw echo pin into the clk domain and produces registered
// single-cycle rise and fall pulses from the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;
  logic rise_reg;
  logic fall_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      meta_reg <= echo;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      rise_reg <= sync_reg & ~prev_reg;
      fall_reg <= ~sync_reg & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/prox_ping_scheduler.sv
// Round-robin ultrasonic ping scheduler: one sensor pings at a time, the
// echo width is measured with a timeout, and a per-sensor near flag is kept.
module prox_ping_scheduler
  import prox_pkg::*;
#(
  parameter int N_SENSORS      = 2,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int THRESH_CYCLES  = DEF_THRESH_CYCLES,
  parameter int HYST_CYCLES    = DEF_HYST_CYCLES,
  parameter int CNT_W          = 23
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [N_SENSORS-1:0]                echo,
  output logic [N_SENSORS-1:0]                trig,
  output logic [N_SENSORS-1:0]                near,
  output logic [CNT_W-1:0]                    echo_cycles,
  output logic [id_width(N_SENSORS)-1:0]      sample_id,
  output logic                                sample_valid,
  output logic                                timeout
);

  localparam int ID_W = id_width(N_SENSORS);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_BELOW   = CNT_W'(THRESH_CYCLES);
  localparam logic [CNT_W-1:0] FAR_AT       = CNT_W'(THRESH_CYCLES + HYST_CYCLES);
  localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(N_SENSORS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t                 state_reg, state_next;
  logic [ID_W-1:0]        cur_reg, cur_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0]       tcnt_reg, tcnt_next;
  logic [CNT_W-1:0]       width_reg, width_next;
  logic [N_SENSORS-1:0]   near_reg, near_next;
  logic [CNT_W-1:0]       echo_cycles_reg, echo_cycles_next;
  logic [ID_W-1:0]        sample_id_reg, sample_id_next;
  logic                   sample_valid_reg, sample_valid_next;
  logic                   timeout_reg, timeout_next;

  logic [N_SENSORS-1:0]   rise_vec;
  logic [N_SENSORS-1:0]   fall_vec;
  logic                   rise_cur;
  logic                   fall_cur;
  logic                   end_on_fall;
  logic                   end_on_timeout;

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_sensor
      echo_sync u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .echo  (echo[gi]),
        .rise  (rise_vec[gi]),
        .fall  (fall_vec[gi])
      );

      // Trigger is decoded straight from state so reset drops it at once.
      assign trig[gi] = (state_reg == ST_TRIG) && (cur_reg == ID_W'(gi));
    end
  endgenerate

  assign rise_cur = rise_vec[cur_reg];
  assign fall_cur = fall_vec[cur_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cur_reg          <= '0;
      cnt_reg          <= '0;
      tcnt_reg         <= '0;
      width_reg        <= '0;
      near_reg         <= '0;
      echo_cycles_reg  <= '0;
      sample_id_reg    <= '0;
      sample_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cur_reg          <= cur_next;
      cnt_reg          <= cnt_next;
      tcnt_reg         <= tcnt_next;
      width_reg        <= width_next;
      near_reg         <= near_next;
      echo_cycles_reg  <= echo_cycles_next;
      sample_id_reg    <= sample_id_next;
      sample_valid_reg <= sample_valid_next;
      timeout_reg      <= timeout_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cur_next          = cur_reg;
    cnt_next          = cnt_reg;
    tcnt_next         = tcnt_reg;
    width_next        = width_reg;
    near_next         = near_reg;
    echo_cycles_next  = echo_cycles_reg;
    sample_id_next    = sample_id_reg;
    sample_valid_next = 1'b0;
    timeout_next      = 1'b0;
    end_on_fall       = 1'b0;
    end_on_timeout    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_TRIG;
          cnt_next   = '0;
        end
      end

      ST_TRIG: begin
        if (cnt_reg == TRIG_LAST) begin
          state_next = ST_WAIT_RISE;
          cnt_next   = '0;
          tcnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // Timeout is tested before the rise so the counter can never pass the limit.
      ST_WAIT_RISE: begin
        if (tcnt_reg == TIMEOUT_LAST) begin
          end_on_timeout = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + CNT_ONE;
          if (rise_cur) begin
            state_next = ST_MEASURE;
            width_next = CNT_ONE;
          end
        end
      end

      // A fall in the same cycle as the timeout still yields a real sample.
      ST_MEASURE: begin
        if (fall_cur) begin
          end_on_fall = 1'b1;
        end else if (tcnt_reg == TIMEOUT_LAST) begin
          end_on_timeout = 1'b1;
        end else begin
          tcnt_next  = tcnt_reg + CNT_ONE;
          width_next = width_reg + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          cur_next   = (cur_reg == LAST_ID) ? '0 : cur_reg + ID_W'(1);
          state_next = enable ? ST_TRIG : ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (end_on_fall || end_on_timeout) begin
      state_next        = ST_GAP;
      cnt_next          = '0;
      sample_id_next    = cur_reg;
      sample_valid_next = 1'b1;
    end

    if (end_on_fall) begin
      echo_cycles_next = width_reg;
      if (width_reg < NEAR_BELOW) begin
        near_next[cur_reg] = 1'b1;
      end else if (width_reg >= FAR_AT) begin
        near_next[cur_reg] = 1'b0;
      end
    end

    if (end_on_timeout) begin
      echo_cycles_next   = TIMEOUT_SAT;
      timeout_next       = 1'b1;
      near_next[cur_reg] = 1'b0;
    end
  end

  assign near         = near_reg;
  assign echo_cycles  = echo_cycles_reg;
  assign sample_id    = sample_id_reg;
  assign sample_valid = sample_valid_reg;
  assign timeout      = timeout_reg;

endmodule
